// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester (inst/data) arbiter onto one SRAM-like memory port
module sram_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    // Counter wide enough to hold STARVE_MAX; never narrower than one bit.
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    state_t           state;
    state_t           state_nxt;
    owner_t           owner;
    owner_t           owner_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_nxt;

    logic any_req;
    logic starved;
    logic pick_inst;

    // Data normally wins; inst wins only when alone or after STARVE_MAX data grants in a row.
    assign any_req   = inst_req | data_req;
    assign starved   = (starve_cnt == CNT_MAX);
    assign pick_inst = inst_req & (~data_req | starved);

    // Read data is a straight pass-through; the *_data_ok strobes qualify it.
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    // State, owner and starvation counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for address accept, then for the response.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        starve_nxt = starve_cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ADDR;
                    if (pick_inst) begin
                        owner_nxt  = OWN_INST;
                        starve_nxt = '0;
                    end else begin
                        owner_nxt = OWN_DATA;
                        if (!inst_req) begin
                            starve_nxt = '0;
                        end else if (!starved) begin
                            starve_nxt = starve_cnt + CNT_ONE;
                        end
                    end
                end
            end
            ADDR: begin
                if (mem_addr_ok) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (mem_data_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory request mux and handshake routing to the current owner only.
    always_comb begin
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_wstrb    = 4'h0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state)
            ADDR: begin
                mem_req = 1'b1;
                if (owner == OWN_DATA) begin
                    mem_wr       = data_wr;
                    mem_wstrb    = data_wstrb;
                    mem_addr     = data_addr;
                    mem_wdata    = data_wdata;
                    data_addr_ok = mem_addr_ok;
                end else begin
                    mem_addr     = inst_addr;
                    inst_addr_ok = mem_addr_ok;
                end
            end
            RESP: begin
                if (owner == OWN_DATA) begin
                    data_data_ok = mem_data_ok;
                end else begin
                    inst_data_ok = mem_data_ok;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'h0;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [3:0]  data_wstrb = 4'h0;
    logic [31:0] data_addr = 32'h0;
    logic [31:0] data_wdata = 32'h0;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    sram_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are changed 2 ns after the edge, outputs checked 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        cyc(); cyc(); #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0000) begin errors++;
            $display("FAIL reset_handshakes: got %b expected 0000", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}); end
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic test_inst_fetch();
        apply_reset();
        inst_req = 1'b1; inst_addr = 32'h1C00_0000;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0280_0405;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_c0_mem_req: got %b expected 0", mem_req); end
        cyc(); #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch_c1_mem_req: got %b expected 1", mem_req); end
        checks++; if (mem_addr !== 32'h1C00_0000) begin errors++; $display("FAIL fetch_c1_mem_addr: got %h expected 1c000000", mem_addr); end
        checks++; if ({mem_wr, mem_wstrb} !== 5'b0 || mem_wdata !== 32'h0) begin errors++;
            $display("FAIL fetch_c1_wr_fields: got wr=%b wstrb=%h wdata=%h expected all 0", mem_wr, mem_wstrb, mem_wdata); end
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++;
            $display("FAIL fetch_c1_addr_ok: got %b expected 10", {inst_addr_ok, data_addr_ok}); end
        cyc(); inst_req = 1'b0; #1;
        checks++; if ({inst_data_ok, data_data_ok, mem_req} !== 3'b100) begin errors++;
            $display("FAIL fetch_c2_data_ok: got %b expected 100", {inst_data_ok, data_data_ok, mem_req}); end
        checks++; if (inst_rdata !== 32'h0280_0405) begin errors++; $display("FAIL fetch_c2_rdata: got %h expected 02800405", inst_rdata); end
        cyc(); #1;
        checks++; if ({mem_req, inst_data_ok, inst_addr_ok} !== 3'b000) begin errors++;
            $display("FAIL fetch_c3_idle: got %b expected 000", {mem_req, inst_data_ok, inst_addr_ok}); end
    endtask

    task automatic test_priority();
        apply_reset();
        inst_req = 1'b1; inst_addr = 32'h1C00_0040;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_1000;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
        cyc(); #1;
        checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10 || mem_addr !== 32'h0000_1000) begin errors++;
            $display("FAIL prio_first_grant: got dok=%b iok=%b addr=%h expected data at 00001000", data_addr_ok, inst_addr_ok, mem_addr); end
        cyc(); data_req = 1'b0; #1;
        checks++; if ({data_data_ok, inst_data_ok} !== 2'b10 || data_rdata !== 32'h1234_5678) begin errors++;
            $display("FAIL prio_data_resp: got %b rdata=%h expected 10 12345678", {data_data_ok, inst_data_ok}, data_rdata); end
        cyc(); #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL prio_idle_gap: got %b expected 0", mem_req); end
        cyc(); #1;
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10 || mem_addr !== 32'h1C00_0040) begin errors++;
            $display("FAIL prio_second_grant: got iok=%b dok=%b addr=%h expected inst at 1c000040", inst_addr_ok, data_addr_ok, mem_addr); end
        cyc(); inst_req = 1'b0; #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++;
            $display("FAIL prio_inst_resp: got %b expected 10", {inst_data_ok, data_data_ok}); end
        cyc();
    endtask

    task automatic test_starvation();
        logic exp_inst;
        apply_reset();
        inst_req = 1'b1; inst_addr = 32'h1C00_0100;
        data_req = 1'b1; data_addr = 32'h0000_2000;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        for (int r = 0; r < 7; r++) begin
            exp_inst = (r == 4);
            #1;
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL starve_r%0d_idle: got %b expected 0", r, mem_req); end
            cyc(); #1;
            checks++; if ({inst_addr_ok, data_addr_ok} !== {exp_inst, ~exp_inst}) begin errors++;
                $display("FAIL starve_r%0d_grant: got %b expected %b", r, {inst_addr_ok, data_addr_ok}, {exp_inst, ~exp_inst}); end
            cyc(); #1;
            checks++; if ({inst_data_ok, data_data_ok} !== {exp_inst, ~exp_inst}) begin errors++;
                $display("FAIL starve_r%0d_resp: got %b expected %b", r, {inst_data_ok, data_data_ok}, {exp_inst, ~exp_inst}); end
            cyc();
        end
        clear_inputs();
    endtask

    task automatic test_store_wait();
        apply_reset();
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'h3; data_addr = 32'h0000_0008; data_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            cyc();
            mem_addr_ok = (c == 2);
            #1;
            checks++; if ({mem_req, mem_wr, mem_wstrb} !== 6'b11_0011 || mem_addr !== 32'h8 || mem_wdata !== 32'hDEAD_BEEF) begin errors++;
                $display("FAIL store_addr_c%0d_fields: got req=%b wr=%b wstrb=%h addr=%h wdata=%h expected 1 1 3 00000008 deadbeef",
                         c, mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata); end
            checks++; if (data_addr_ok !== (c == 2)) begin errors++;
                $display("FAIL store_addr_c%0d_ok: got %b expected %b", c, data_addr_ok, (c == 2)); end
        end
        cyc(); mem_addr_ok = 1'b0; data_req = 1'b0; #1;
        checks++; if ({mem_req, data_data_ok} !== 2'b00) begin errors++;
            $display("FAIL store_resp_wait: got %b expected 00", {mem_req, data_data_ok}); end
        cyc(); mem_data_ok = 1'b1; #1;
        checks++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin errors++;
            $display("FAIL store_done: got %b expected 10", {data_data_ok, inst_data_ok}); end
        cyc(); mem_data_ok = 1'b0;
    endtask

    task automatic test_reset_in_flight();
        apply_reset();
        inst_req = 1'b1; inst_addr = 32'h1C00_0200; mem_addr_ok = 1'b1;
        cyc(); cyc(); inst_req = 1'b0; mem_addr_ok = 1'b0; reset = 1'b1; #1;
        checks++; if ({mem_req, inst_data_ok} !== 2'b00) begin errors++;
            $display("FAIL rst_resp_pre: got %b expected 00", {mem_req, inst_data_ok}); end
        cyc(); reset = 1'b0; mem_data_ok = 1'b1; #1;
        checks++; if ({mem_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 5'b0) begin errors++;
            $display("FAIL rst_resp_late_data_ok: got %b expected 00000", {mem_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}); end
        cyc(); #1;
        checks++; if ({mem_req, inst_data_ok} !== 2'b00) begin errors++;
            $display("FAIL rst_resp_still_idle: got %b expected 00", {mem_req, inst_data_ok}); end
        clear_inputs();
        data_req = 1'b1; data_addr = 32'h0000_0300;
        cyc(); reset = 1'b1; data_req = 1'b0; #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_addr_pre: got %b expected 1", mem_req); end
        cyc(); reset = 1'b0; mem_addr_ok = 1'b1; #1;
        checks++; if ({mem_req, data_addr_ok} !== 2'b00) begin errors++;
            $display("FAIL rst_addr_dropped: got %b expected 00", {mem_req, data_addr_ok}); end
        clear_inputs();
    endtask

    task automatic test_spurious_data_ok();
        apply_reset();
        mem_data_ok = 1'b1; mem_addr_ok = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cyc(); #1;
            checks++; if ({mem_req, inst_data_ok, data_data_ok} !== 3'b000) begin errors++;
                $display("FAIL spurious_c%0d: got %b expected 000", c, {mem_req, inst_data_ok, data_data_ok}); end
        end
        inst_req = 1'b1; inst_addr = 32'h1C00_0400;
        cyc(); #1;
        checks++; if ({mem_req, inst_addr_ok} !== 2'b11) begin errors++;
            $display("FAIL spurious_then_grant: got %b expected 11", {mem_req, inst_addr_ok}); end
        cyc(); inst_req = 1'b0; #1;
        checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL spurious_then_resp: got %b expected 1", inst_data_ok); end
        cyc();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_inst_fetch();
        test_priority();
        test_starvation();
        test_store_wait();
        test_reset_in_flight();
        test_spurious_data_ok();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
